q_exploit_agent: RTL and testbench
==================================

// Module: q_exploit_agent
// PURPOSE
//  Greedy-policy initiator for the 6x6 maze Q-learning exploit phase. Scans the 4 Q entries of the current state,
//  picks the argmax action and issues it to the maze step responder. Consumes the returned next_state and repeats
//  until target reached, step limit hit or error. Sits between the Q-table RAM and the maze step/move block.
// PARAMETERS
//  MAX_STEPS  64  steps issued before giving up (timeout); 1..255
//  CNT_W      8   width of step_count
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-high reset
//  start         in   1   pulse: begin run (ignored while busy)
//  start_state   in   6   first maze state, valid 1..36 (sampled on start)
//  target_state  in   6   goal maze state (sampled on start)
//  q_rd_state    out  6   Q-table read address: state
//  q_rd_act      out  2   Q-table read address: action
//  q_rd_data     in   32  signed Q value, valid exactly 1 cycle after address
//  step_req      out  1   action valid to step responder; held until step_ack
//  action        out  4   0:+6 1:+1 2:-6 3:-1 (upper 2 bits always 0)
//  step_ack      in   1   responder done; next_state valid same cycle
//  next_state    in   6   state returned by responder
//  cur_state     out  6   current agent state
//  step_count    out  CNT_W  steps completed this run
//  busy          out  1   high from start accept until done_o
//  done_o        out  1   1-cycle pulse at run end
//  reached       out  1   run ended at target (held until next start)
//  timeout       out  1   run ended at MAX_STEPS (held)
//  err           out  1   illegal start_state/next_state (0 or >36) (held)
//  loop          out  1   revisit detected (held; see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0 (cur_state=0, step_count=0, action=0). Reset mid-run aborts immediately, no done_o.
//  FSM: IDLE -> CHECK -> SCAN -> REQ -> UPDATE -> CHECK ... -> FIN -> IDLE.
//   IDLE: start=1 -> latch states, clear flags/count, busy=1, cur_state=start_state -> CHECK.
//   CHECK: cur_state invalid -> err; ==target -> reached; step_count==MAX_STEPS -> timeout; any -> FIN, else SCAN.
//   SCAN: issue q_rd_act 0,1,2,3 on consecutive cycles (q_rd_state=cur_state); compare data as signed 32-bit.
//     Strictly-greater replaces best, so ties keep lowest action index. 5 cycles (4 addr + 1 latency) -> REQ.
//   REQ: step_req=1, action=best, stable until step_ack sampled high (ack in first REQ cycle accepted).
//     On ack: capture next_state -> UPDATE. step_ack outside REQ ignored.
//   UPDATE: cur_state<=next_state, step_count+1 (no wrap; MAX_STEPS < 2^CNT_W) -> CHECK.
//   FIN: done_o=1 one cycle, busy=0 -> IDLE. Flags held until next accepted start.
//  Priority in CHECK: err > reached > loop > timeout.
//  start==target: done_o 2 cycles after start, step_count=0, reached=1, no step_req.
//  Per-step latency: CHECK 1 + SCAN 5 + REQ (1+responder wait) + UPDATE 1.
// CONFIGURATION
//  Q_EXPLOIT_LOOP_DETECT_EN defined: 37-bit visited mask cleared on start, bit set in UPDATE; captured next_state
//   already visited (incl. blocked move returning same state) -> loop=1, end run via FIN.
//  Not defined: no mask; loop tied 0; only MAX_STEPS bounds a deterministic cycle.
// STRUCTURE
//  Package q_maze_pkg: STATE_W=6, N_STATES=37, N_ACT=4, Q_W=32, state_t, q_t (signed), action_e
//   (ACT_DOWN=0, ACT_RIGHT=1, ACT_UP=2, ACT_LEFT=3), MIN_STATE=1, MAX_STATE=36.
//  Sub-module q_argmax_scan: streams 4 signed values + index, outputs best index on valid; clear on scan start.
// TESTING
//  1 Q(1,*)={5,9,9,-3}, start=1,target=2, responder returns 2 -> action=1 (tie keeps lower), reached=1, step_count=1.
//  2 start_state=target_state=14 -> done_o 2 cycles after start, reached=1, step_req never asserted.
//  3 Responder delays step_ack 7 cycles -> step_req/action stable all 7 cycles; ack with step_req same cycle accepted.
//  4 Responder always returns cur_state, MAX_STEPS=4, macro off -> timeout=1, step_count=4; macro on -> loop=1, count=1.
//  5 start_state=0 -> err=1, done_o, no Q reads; responder returns 40 mid-run -> err=1 after UPDATE.
//  6 rst asserted during REQ -> next cycle step_req=0, busy=0, flags 0, no done_o; new start runs normally.

Source files
------------

// File: rtl/q_maze_pkg.sv
// Shared types and constants for the 6x6 maze Q-learning exploit agent.
// States are numbered 1..36; 0 and 37..63 are illegal encodings.
package q_maze_pkg;

    localparam int STATE_W   = 6;
    localparam int N_STATES  = 37;
    localparam int N_ACT     = 4;
    localparam int Q_W       = 32;
    localparam int MIN_STATE = 1;
    localparam int MAX_STATE = 36;

    typedef logic [STATE_W-1:0]     state_t;
    typedef logic signed [Q_W-1:0]  q_t;

    // Move encoding: DOWN=+6, RIGHT=+1, UP=-6, LEFT=-1
    typedef enum logic [1:0] {
        ACT_DOWN  = 2'd0,
        ACT_RIGHT = 2'd1,
        ACT_UP    = 2'd2,
        ACT_LEFT  = 2'd3
    } action_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SCAN,
        ST_REQ,
        ST_UPDATE,
        ST_FIN
    } agent_state_e;

    // True when s encodes a real maze cell
    function automatic logic state_valid(input state_t s);
        return (s >= state_t'(MIN_STATE)) && (s <= state_t'(MAX_STATE));
    endfunction

endpackage

// File: rtl/q_argmax_scan.sv
// Streaming argmax over the Q values of one state. Values arrive one per
// cycle with their action index; a strictly-greater value replaces the
// running best, so ties keep the lowest index seen first.
module q_argmax_scan
    import q_maze_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clear_i,
    input  logic    valid_i,
    input  action_e idx_i,
    input  q_t      data_i,
    output action_e best_idx_o
);

    logic    have_q;
    q_t      best_val_q;
    action_e best_idx_q;

    // Track the running maximum; the first value of a scan is always taken
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            have_q     <= 1'b0;
            best_val_q <= '0;
            best_idx_q <= ACT_DOWN;
        end else if (clear_i) begin
            have_q     <= 1'b0;
            best_val_q <= '0;
            best_idx_q <= ACT_DOWN;
        end else if (valid_i && (!have_q || (data_i > best_val_q))) begin
            have_q     <= 1'b1;
            best_val_q <= data_i;
            best_idx_q <= idx_i;
        end
    end

    assign best_idx_o = best_idx_q;

endmodule

// File: rtl/q_exploit_agent.sv
// Greedy-policy exploit agent: for each state, reads the 4 Q entries,
// issues the argmax action to the maze step responder and follows the
// returned state until target, step limit, illegal state or revisit.
// Optional feature macro: Q_EXPLOIT_LOOP_DETECT_EN (visited-state mask).
module q_exploit_agent
    import q_maze_pkg::*;
#(
    parameter int MAX_STEPS = 64,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [5:0]         start_state,
    input  logic [5:0]         target_state,
    output logic [5:0]         q_rd_state,
    output logic [1:0]         q_rd_act,
    input  logic signed [31:0] q_rd_data,
    output logic               step_req,
    output logic [3:0]         action,
    input  logic               step_ack,
    input  logic [5:0]         next_state,
    output logic [5:0]         cur_state,
    output logic [CNT_W-1:0]   step_count,
    output logic               busy,
    output logic               done_o,
    output logic               reached,
    output logic               timeout,
    output logic               err,
    output logic               loop
);

    agent_state_e     state_q;
    state_t           cur_state_q;
    state_t           target_q;
    state_t           next_q;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       scan_cnt_q;
    logic             step_req_q;
    logic             busy_q;
    logic             done_q;
    logic             reached_q;
    logic             timeout_q;
    logic             err_q;
    logic             loop_q;

    logic             end_err;
    logic             end_reached;
    logic             end_timeout;
    logic             scan_clear;
    logic             scan_valid;
    action_e          scan_idx;
    action_e          best_idx;
    logic             loop_hit;

    // Run-end decisions in CHECK, in priority order err > reached > timeout
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        end_err     = 1'b0;
        end_reached = 1'b0;
        end_timeout = 1'b0;
        if (!state_valid(cur_state_q)) begin
            end_err = 1'b1;
        end else if (cur_state_q == target_q) begin
            end_reached = 1'b1;
        end else if (count_q == CNT_W'(MAX_STEPS)) begin
            end_timeout = 1'b1;
        end
    end

    // Scan control: address k goes out in scan cycle k, its data returns in
    // cycle k+1, so the scanner consumes data in cycles 1..4
    always_comb begin
        scan_clear = (state_q == ST_SCAN) && (scan_cnt_q == 3'd0);
        scan_valid = (state_q == ST_SCAN) && (scan_cnt_q != 3'd0);
        scan_idx   = action_e'(scan_cnt_q[1:0] - 2'd1);
    end

    q_argmax_scan u_scan (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (scan_clear),
        .valid_i    (scan_valid),
        .idx_i      (scan_idx),
        .data_i     (q_rd_data),
        .best_idx_o (best_idx)
    );

`ifdef Q_EXPLOIT_LOOP_DETECT_EN
    logic [N_STATES-1:0] visited_q;

    // Flag a returned state that this run has already moved into
    always_comb begin
        loop_hit = state_valid(next_state) && visited_q[next_state];
    end

    // Visited mask: cleared on accepted start, marked when a move is applied
    always_ff @(posedge clk) begin
        // NOTE: the mask is a small flop vector, so it is reset explicitly;
        // a RAM-style table would instead be cleared by the start sequence.
        if (rst) begin
            visited_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            visited_q <= '0;
        end else if ((state_q == ST_UPDATE) && state_valid(next_q)) begin
            visited_q[next_q] <= 1'b1;
        end
    end
`else
    assign loop_hit = 1'b0;
`endif

    // Main control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_state_q <= '0;
            target_q    <= '0;
            next_q      <= '0;
            count_q     <= '0;
            scan_cnt_q  <= '0;
            step_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reached_q   <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= 1'b0;
            loop_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cur_state_q <= start_state;
                        target_q    <= target_state;
                        count_q     <= '0;
                        reached_q   <= 1'b0;
                        timeout_q   <= 1'b0;
                        err_q       <= 1'b0;
                        loop_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (end_err || end_reached || end_timeout) begin
                        err_q     <= end_err;
                        reached_q <= end_reached;
                        timeout_q <= end_timeout;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= ST_FIN;
                    end else begin
                        scan_cnt_q <= '0;
                        state_q    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (scan_cnt_q == 3'd4) begin
                        step_req_q <= 1'b1;
                        state_q    <= ST_REQ;
                    end else begin
                        scan_cnt_q <= scan_cnt_q + 3'd1;
                    end
                end
                ST_REQ: begin
                    if (step_ack) begin
                        step_req_q <= 1'b0;
                        next_q     <= next_state;
                        if (loop_hit) begin
                            loop_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            state_q <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    cur_state_q <= next_q;
                    count_q     <= count_q + CNT_W'(1);
                    state_q     <= ST_CHECK;
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign q_rd_state = cur_state_q;
    assign q_rd_act   = scan_cnt_q[1:0];
    assign step_req   = step_req_q;
    assign action     = {2'b00, best_idx};
    assign cur_state  = cur_state_q;
    assign step_count = count_q;
    assign busy       = busy_q;
    assign done_o     = done_q;
    assign reached    = reached_q;
    assign timeout    = timeout_q;
    assign err        = err_q;
    assign loop       = loop_q;

endmodule

// File: tb/tb_q_exploit_agent.sv
// Directed bench for q_exploit_agent (MAX_STEPS overridden to 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_q_exploit_agent;
    import q_maze_pkg::*;

    localparam int MAXS = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [5:0]         start_state = '0;
    logic [5:0]         target_state = '0;
    logic [5:0]         q_rd_state;
    logic [1:0]         q_rd_act;
    logic signed [31:0] q_rd_data = '0;
    logic               step_req;
    logic [3:0]         action;
    logic               step_ack = 1'b0;
    logic [5:0]         next_state = '0;
    logic [5:0]         cur_state;
    logic [7:0]         step_count;
    logic               busy;
    logic               done_o;
    logic               reached;
    logic               timeout;
    logic               err;
    logic               loop;

    int total = 0;
    int bad   = 0;
    int qmem [0:63][0:3];

    q_exploit_agent #(.MAX_STEPS(MAXS), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_state  (start_state),
        .target_state (target_state),
        .q_rd_state   (q_rd_state),
        .q_rd_act     (q_rd_act),
        .q_rd_data    (q_rd_data),
        .step_req     (step_req),
        .action       (action),
        .step_ack     (step_ack),
        .next_state   (next_state),
        .cur_state    (cur_state),
        .step_count   (step_count),
        .busy         (busy),
        .done_o       (done_o),
        .reached      (reached),
        .timeout      (timeout),
        .err          (err),
        .loop         (loop)
    );

    always #5 clk = ~clk;

    // Q-table RAM model: one-cycle read latency
    always @(posedge clk) q_rd_data <= qmem[q_rd_state][q_rd_act];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic r, input logic t,
                               input logic e, input logic l);
        check({tag, ".reached"}, 32'(reached), 32'(r));
        check({tag, ".timeout"}, 32'(timeout), 32'(t));
        check({tag, ".err"},     32'(err),     32'(e));
        check({tag, ".loop"},    32'(loop),    32'(l));
    endtask

    task automatic set_q(input int s, input int a0, input int a1, input int a2, input int a3);
        qmem[s][0] = a0;
        qmem[s][1] = a1;
        qmem[s][2] = a2;
        qmem[s][3] = a3;
    endtask

    task automatic do_start(input logic [5:0] s, input logic [5:0] t);
        start_state  = s;
        target_state = t;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (step_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".req_seen"}, 32'(seen), 32'd1);
    endtask

    // Answer one step request after 'delay' idle cycles, checking stability
    task automatic serve(input string tag, input int delay,
                         input logic [5:0] ns, input logic [3:0] exp_act);
        wait_req(tag);
        for (int d = 0; d < delay; d++) begin
            check({tag, ".hold_req"}, 32'(step_req), 32'd1);
            check({tag, ".hold_act"}, 32'(action), 32'(exp_act));
            @(negedge clk);
        end
        check({tag, ".action"}, 32'(action), 32'(exp_act));
        step_ack   = 1'b1;
        next_state = ns;
        @(negedge clk);
        step_ack   = 1'b0;
        next_state = '0;
        check({tag, ".req_drop"}, 32'(step_req), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 64; s++)
            for (int a = 0; a < 4; a++)
                qmem[s][a] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done_o), 32'd0);
        check("rst.req", 32'(step_req), 32'd0);
        check("rst.cur", 32'(cur_state), 32'd0);
        check("rst.count", 32'(step_count), 32'd0);
        check("rst.action", 32'(action), 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: tie between actions 1 and 2 keeps 1; one step reaches target
        set_q(1, 5, 9, 9, -3);
        do_start(6'd1, 6'd2);
        check("t1.busy", 32'(busy), 32'd1);
        serve("t1", 0, 6'd2, 4'd1);
        wait_done("t1");
        check("t1.count", 32'(step_count), 32'd1);
        check("t1.cur", 32'(cur_state), 32'd2);
        check_flags("t1", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1.done_pulse", 32'(done_o), 32'd0);
        check("t1.reached_held", 32'(reached), 32'd1);

        // 2: start == target ends two cycles after start, no request
        do_start(6'd14, 6'd14);
        check("t2.done_early", 32'(done_o), 32'd0);
        check("t2.req_c1", 32'(step_req), 32'd0);
        @(negedge clk);
        check("t2.done", 32'(done_o), 32'd1);
        check("t2.req_c2", 32'(step_req), 32'd0);
        check("t2.count", 32'(step_count), 32'd0);
        check_flags("t2", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // 3: signed argmax picks UP (3 beats negatives); 7-cycle ack delay
        set_q(20, -5, -7, 3, -2);
        do_start(6'd20, 6'd14);
        serve("t3", 7, 6'd14, 4'd2);
        wait_done("t3");
        check("t3.count", 32'(step_count), 32'd1);
        check_flags("t3", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // 4: blocked move always returns the same state
        set_q(8, 0, 0, 0, 0);
        do_start(6'd8, 6'd30);
`ifdef Q_EXPLOIT_LOOP_DETECT_EN
        serve("t4.s1", 0, 6'd8, 4'd0);
        serve("t4.s2", 0, 6'd8, 4'd0);
        wait_done("t4");
        check("t4.count", 32'(step_count), 32'd1);
        check_flags("t4", 1'b0, 1'b0, 1'b0, 1'b1);
`else
        for (int k = 0; k < MAXS; k++) serve("t4.s", 1, 6'd8, 4'd0);
        wait_done("t4");
        check("t4.count", 32'(step_count), 32'(MAXS));
        check_flags("t4", 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        @(negedge clk);

        // 5a: illegal start state ends immediately with err
        do_start(6'd0, 6'd5);
        check("t5a.req", 32'(step_req), 32'd0);
        @(negedge clk);
        check("t5a.done", 32'(done_o), 32'd1);
        check("t5a.req2", 32'(step_req), 32'd0);
        check_flags("t5a", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // 5b: responder returns out-of-range state 40
        set_q(3, 1, 0, 0, 0);
        do_start(6'd3, 6'd20);
        serve("t5b", 0, 6'd40, 4'd0);
        wait_done("t5b");
        check("t5b.cur", 32'(cur_state), 32'd40);
        check("t5b.count", 32'(step_count), 32'd1);
        check_flags("t5b", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // 6: reset during the second request aborts with no done pulse
        set_q(5, 0, 0, 0, 0);
        set_q(11, 0, 4, 0, 0);
        do_start(6'd5, 6'd6);
        serve("t6.s1", 0, 6'd11, 4'd0);
        wait_req("t6.s2");
        check("t6.pre_count", 32'(step_count), 32'd1);
        check("t6.pre_act", 32'(action), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6.req", 32'(step_req), 32'd0);
        check("t6.busy", 32'(busy), 32'd0);
        check("t6.done", 32'(done_o), 32'd0);
        check("t6.cur", 32'(cur_state), 32'd0);
        check("t6.count", 32'(step_count), 32'd0);
        check_flags("t6", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("t6.no_done1", 32'(done_o), 32'd0);
        @(negedge clk);
        check("t6.no_done2", 32'(done_o), 32'd0);
        check("t6.idle_busy", 32'(busy), 32'd0);

        // 6b: new run after reset picks LEFT and reaches target
        set_q(5, 1, 2, 3, 10);
        do_start(6'd5, 6'd4);
        serve("t6b", 2, 6'd4, 4'd3);
        wait_done("t6b");
        check("t6b.count", 32'(step_count), 32'd1);
        check("t6b.cur", 32'(cur_state), 32'd4);
        check_flags("t6b", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
